// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI master for 10-bit command frames, with an 8-bit read-back after read-data commands.
// Optional macro SPI_MASTER_ERR_CHK_EN: flags a read-data frame that has no preceding read-address frame.
module spi_master_ctrl #(
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [9:0] cmd_data,
  output logic       cmd_ready,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       busy,
  output logic       err
);

  typedef enum logic [2:0] {IDLE, START, SHIFT, TURN, RECV, STOP} state_e;

  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

  state_e     state_q;
  logic [9:0] sh_q;
  logic [1:0] cmd_q;
  logic [3:0] cnt_q;
  logic [7:0] rx_q;
  logic [7:0] rx_d;
  logic       ss_n_q;
  logic       mosi_q;
  logic       ready_q;
  logic       busy_q;
  logic [7:0] rd_data_q;
  logic       rd_valid_q;
`ifdef SPI_MASTER_ERR_CHK_EN
  logic       err_q;
  logic       rd_addr_pend_q;
`endif

  always_comb begin
    rx_d = {rx_q[6:0], MISO};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      sh_q           <= '0;
      cmd_q          <= '0;
      cnt_q          <= '0;
      rx_q           <= '0;
      ss_n_q         <= 1'b1;
      mosi_q         <= 1'b0;
      ready_q        <= 1'b1;
      busy_q         <= 1'b0;
      rd_data_q      <= '0;
      rd_valid_q     <= 1'b0;
`ifdef SPI_MASTER_ERR_CHK_EN
      err_q          <= 1'b0;
      rd_addr_pend_q <= 1'b0;
`endif
    end else begin
      rd_valid_q <= 1'b0;
`ifdef SPI_MASTER_ERR_CHK_EN
      err_q      <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            state_q <= START;
            sh_q    <= cmd_data;
            cmd_q   <= cmd_data[9:8];
            ss_n_q  <= 1'b0;
            mosi_q  <= cmd_data[9];
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
`ifdef SPI_MASTER_ERR_CHK_EN
            err_q   <= (cmd_data[9:8] == 2'b11) && !rd_addr_pend_q;
`endif
          end
        end
        // START shows bit 9 early; SHIFT then walks the shift register MSB-first.
        START: begin
          state_q <= SHIFT;
          mosi_q  <= sh_q[9];
          sh_q    <= {sh_q[8:0], 1'b0};
          cnt_q   <= 4'd9;
        end
        SHIFT: begin
          if (cnt_q != 4'd0) begin
            mosi_q <= sh_q[9];
            sh_q   <= {sh_q[8:0], 1'b0};
            cnt_q  <= cnt_q - 4'd1;
          end else if (cmd_q == 2'b11) begin
            state_q <= TURN;
            mosi_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            state_q <= STOP;
            ss_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
            cnt_q   <= GAP_LOAD;
`ifdef SPI_MASTER_ERR_CHK_EN
            if (cmd_q == 2'b10) rd_addr_pend_q <= 1'b1;
`endif
          end
        end
        TURN: begin
          state_q <= RECV;
          rx_q    <= '0;
          cnt_q   <= 4'd7;
        end
        RECV: begin
          rx_q <= rx_d;
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q    <= STOP;
            ss_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            rd_data_q  <= rx_d;
            rd_valid_q <= 1'b1;
            cnt_q      <= GAP_LOAD;
`ifdef SPI_MASTER_ERR_CHK_EN
            rd_addr_pend_q <= 1'b0;
`endif
          end
        end
        STOP: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          ss_n_q  <= 1'b1;
          mosi_q  <= 1'b0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = ready_q;
  assign SS_n      = ss_n_q;
  assign MOSI      = mosi_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign busy      = busy_q;
`ifdef SPI_MASTER_ERR_CHK_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed self-checking bench for spi_master_ctrl: write, read-back, mid-frame reset, busy input churn.
module tb_spi_master_ctrl;
  localparam int unsigned GAP = 2;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic [9:0] cmd_data;
  logic       cmd_ready;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       busy;
  logic       err;

  spi_master_ctrl #(.GAP_CYCLES(GAP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_data  (cmd_data),
    .cmd_ready (cmd_ready),
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .MISO      (MISO),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  int          low_cnt, gap_cnt, rdv_cnt, err_cnt, hi_bad;
  logic        err_start;
  logic [19:0] mosi_seq;
  logic [7:0]  rdv_data;
  bit          done;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [9:0] d, input bit keep);
    @(negedge clk);
    cmd_data  = d;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!keep) cmd_valid = 1'b0;
  endtask

  // Observes one frame from START to the first IDLE cycle, acting as the slave on MISO.
  task automatic collect(input logic [7:0] sbyte, input bit churn, input logic [9:0] alt);
    low_cnt = 0; gap_cnt = 0; rdv_cnt = 0; err_cnt = 0; hi_bad = 0;
    err_start = 1'b0; mosi_seq = '0; rdv_data = '0; done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      if (rd_valid) begin rdv_cnt++; rdv_data = rd_data; end
      if (err) err_cnt++;
      if (!SS_n) begin
        low_cnt++;
        mosi_seq = {mosi_seq[18:0], MOSI};
        if (low_cnt == 1) err_start = err;
        MISO = (low_cnt >= 13 && low_cnt <= 20) ? sbyte[3'(20 - low_cnt)] : 1'b0;
      end else begin
        MISO = 1'b0;
        if (MOSI) hi_bad++;
        if (cmd_ready) done = 1'b1;
        else gap_cnt++;
      end
      if (churn) cmd_data = done ? alt : ((c % 2 == 1) ? alt : 10'h3FF);
    end
    chk("frame_done", 32'(done), 32'd1);
  endtask

  logic [9:0] fa, fra, frd, fe, fr, fn, f1, f2;
  int         rdv_rst;

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_data = '0; MISO = 1'b0;
    fa = 10'b00_1010_0101; fra = 10'h23C; frd = 10'h300; fe = 10'h35A;
    fr = 10'h3AA; fn = 10'h1A5; f1 = 10'h1C3; f2 = 10'h0F0;

    repeat (3) @(negedge clk);
    chk("rst_ssn",     32'(SS_n), 32'd1);
    chk("rst_mosi",    32'(MOSI), 32'd0);
    chk("rst_rdvalid", 32'(rd_valid), 32'd0);
    chk("rst_rddata",  32'(rd_data), 32'h00);
    chk("rst_busy",    32'(busy), 32'd0);
    chk("rst_err",     32'(err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready",   32'(cmd_ready), 32'd1);

    // Write address: START repeats bit 9 ahead of the ten shifted bits.
    issue(fa, 1'b0);
    collect(8'h00, 1'b0, '0);
    chk("wa_low",   32'(low_cnt), 32'd11);
    chk("wa_mosi",  32'(mosi_seq[10:0]), 32'({fa[9], fa}));
    chk("wa_gap",   32'(gap_cnt), 32'(GAP));
    chk("wa_rdv",   32'(rdv_cnt), 32'd0);
    chk("wa_hi",    32'(hi_bad), 32'd0);

    issue(fra, 1'b0);
    collect(8'h00, 1'b0, '0);
    chk("ra_low",   32'(low_cnt), 32'd11);
    chk("ra_mosi",  32'(mosi_seq[10:0]), 32'({fra[9], fra}));

    issue(frd, 1'b0);
    collect(8'hA7, 1'b0, '0);
    chk("rd_low",   32'(low_cnt), 32'd20);
    chk("rd_mosi",  32'(mosi_seq), 32'({frd[9], frd, 9'b0}));
    chk("rd_rdv",   32'(rdv_cnt), 32'd1);
    chk("rd_data",  32'(rdv_data), 32'hA7);
    chk("rd_err",   32'(err_cnt), 32'd0);
    chk("rd_gap",   32'(gap_cnt), 32'(GAP));

    issue(fa, 1'b0);
    collect(8'h55, 1'b0, '0);
    chk("rd_hold",  32'(rd_data), 32'hA7);
    chk("wr_rdv",   32'(rdv_cnt), 32'd0);

    // Read data with no pending read address.
    issue(fe, 1'b0);
    collect(8'h3D, 1'b0, '0);
    chk("e_low",    32'(low_cnt), 32'd20);
    chk("e_rdv",    32'(rdv_cnt), 32'd1);
    chk("e_data",   32'(rdv_data), 32'h3D);
`ifdef SPI_MASTER_ERR_CHK_EN
    chk("e_errst",  32'(err_start), 32'd1);
    chk("e_errcnt", 32'(err_cnt), 32'd1);
`else
    chk("e_errcnt", 32'(err_cnt), 32'd0);
`endif

    // Reset during SHIFT cycle 5 of a read-data frame.
    issue(fr, 1'b0);
    repeat (6) @(negedge clk);
    chk("mr_pre_ssn", 32'(SS_n), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mr_ssn",   32'(SS_n), 32'd1);
    chk("mr_mosi",  32'(MOSI), 32'd0);
    chk("mr_busy",  32'(busy), 32'd0);
    chk("mr_rdata", 32'(rd_data), 32'h00);
    rdv_rst = 0;
    repeat (2) begin @(negedge clk); if (rd_valid) rdv_rst++; end
    rst_n = 1'b1;
    repeat (25) begin @(negedge clk); if (rd_valid) rdv_rst++; end
    chk("mr_rdv",   32'(rdv_rst), 32'd0);
    chk("mr_ready", 32'(cmd_ready), 32'd1);
    issue(fn, 1'b0);
    collect(8'h00, 1'b0, '0);
    chk("mr_low",   32'(low_cnt), 32'd11);
    chk("mr_mosi2", 32'(mosi_seq[10:0]), 32'({fn[9], fn}));

    // cmd_valid held with churning cmd_data: second frame waits for IDLE.
    issue(f1, 1'b1);
    collect(8'h00, 1'b1, f2);
    chk("ch1_low",  32'(low_cnt), 32'd11);
    chk("ch1_mosi", 32'(mosi_seq[10:0]), 32'({f1[9], f1}));
    chk("ch1_gap",  32'(gap_cnt), 32'(GAP));
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    collect(8'h00, 1'b0, '0);
    chk("ch2_low",  32'(low_cnt), 32'd11);
    chk("ch2_mosi", 32'(mosi_seq[10:0]), 32'({f2[9], f2}));
    chk("ch2_hi",   32'(hi_bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
